melody_sequencer: RTL and testbench

//  Plays a melody by stepping through tone indices 0..7 (Do..Do'), 523/587/659/698/784/880/988/1046 Hz.
//  - Holds each note for a fixed time, then inserts a silent gap.
//  - Generates a square wave per note and pushes 24-bit samples to the audio codec via a ready/write handshake.
//  - Replaces manual switch-based tone selection; outputs also drive the HEX/tone display logic.

---
 rtl/melody_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_melody_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
//  melody_sequencer
//  Steps through a packed melody of tone indices, plays each note as a
//  square wave for a fixed time followed by a silent gap, and writes 24-bit
//  samples to the codec via a ready/write handshake.
//  Optional macro MELODY_LOOP_EN: restart at step 0 after the last gap.
//  Revision: 1.0  initial release
// ============================================================================
module melody_sequencer #(
   parameter int          NUM_STEPS   = 8,
   parameter logic [47:0] MELODY      = 48'h0000_00FA_C688,
   parameter int          NOTE_CYCLES = 12_500_000,
   parameter int          GAP_CYCLES  = 500_000,
   parameter logic [23:0] AMPLITUDE   = 24'h0F_FFFF,
   parameter int          DIV_SHIFT   = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic        audio_ready,
   output logic        audio_write,
   output logic [23:0] sample,
   output logic [2:0]  tone_idx,
   output logic [31:0] half_period,
   output logic [3:0]  step,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

`ifdef MELODY_LOOP_EN
   localparam bit c_LOOP_EN = 1'b1;
`else
   localparam bit c_LOOP_EN = 1'b0;
`endif

   localparam logic [3:0]  c_LAST_STEP = 4'(NUM_STEPS - 1);
   localparam logic [31:0] c_NOTE_LAST = 32'(NOTE_CYCLES - 1);
   localparam logic [31:0] c_GAP_LAST  = 32'(GAP_CYCLES - 1);
   localparam logic [23:0] c_POS       = AMPLITUDE;
   localparam logic [23:0] c_NEG       = -AMPLITUDE;

   state_t      r_state;
   logic        r_start_q;
   logic [31:0] r_note_cnt;
   logic [31:0] r_gap_cnt;
   logic [31:0] r_half_cnt;
   logic        r_phase;
   logic        r_audio_write;
   logic [23:0] r_sample;
   logic [2:0]  r_tone_idx;
   logic [31:0] r_half_period;
   logic [3:0]  r_step;
   logic        r_busy;
   logic        r_done;

   logic [3:0]  w_next_step;
   logic [5:0]  w_melody_bit;
   logic [2:0]  w_next_tone;
   logic [31:0] w_next_hp;
   logic        w_start_rise;
   logic        w_active;
   logic        w_wave_wrap;
   logic        w_gap_end;
   logic        w_enter_play;

   // Half-period in 50 MHz clocks, scaled down and clamped so the wave never stalls
   function automatic logic [31:0] f_half_period(input logic [2:0] tone);
      logic [31:0] base;
      logic [31:0] shifted;
      case (tone)
         3'd0: base = 32'd47801;
         3'd1: base = 32'd42589;
         3'd2: base = 32'd37936;
         3'd3: base = 32'd35817;
         3'd4: base = 32'd31888;
         3'd5: base = 32'd28409;
         3'd6: base = 32'd25303;
         3'd7: base = 32'd23901;
      endcase
      shifted = base >> DIV_SHIFT;
      return (shifted == 32'd0) ? 32'd1 : shifted;
   endfunction

   assign w_next_step  = (r_state == S_GAP && r_step != c_LAST_STEP) ? r_step + 4'd1 : 4'd0;
   assign w_melody_bit = {1'b0, w_next_step, 1'b0} + {2'b00, w_next_step};
   assign w_next_tone  = MELODY[w_melody_bit +: 3];
   assign w_next_hp    = f_half_period(w_next_tone);
   assign w_start_rise = start & ~r_start_q;
   assign w_active     = (r_state == S_PLAY) || (r_state == S_GAP);
   assign w_wave_wrap  = (r_half_cnt == r_half_period - 32'd1);
   assign w_gap_end    = (r_state == S_GAP) && (r_gap_cnt == c_GAP_LAST);
   assign w_enter_play = (((r_state == S_IDLE) || (r_state == S_DONE)) && w_start_rise) ||
                         (w_gap_end && ((r_step != c_LAST_STEP) || c_LOOP_EN));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_start_q     <= 1'b0;
         r_note_cnt    <= 32'd0;
         r_gap_cnt     <= 32'd0;
         r_half_cnt    <= 32'd0;
         r_phase       <= 1'b0;
         r_audio_write <= 1'b0;
         r_sample      <= 24'd0;
         r_tone_idx    <= 3'd0;
         r_half_period <= 32'd0;
         r_step        <= 4'd0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_start_q     <= start;
         r_audio_write <= w_active & audio_ready & ~r_audio_write;
         if (stop) begin
            r_state       <= S_IDLE;
            r_note_cnt    <= 32'd0;
            r_gap_cnt     <= 32'd0;
            r_half_cnt    <= 32'd0;
            r_phase       <= 1'b0;
            r_audio_write <= 1'b0;
            r_sample      <= 24'd0;
            r_tone_idx    <= 3'd0;
            r_half_period <= 32'd0;
            r_step        <= 4'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
         end else if (w_enter_play) begin
            r_state       <= S_PLAY;
            r_note_cnt    <= 32'd0;
            r_gap_cnt     <= 32'd0;
            r_half_cnt    <= 32'd0;
            r_phase       <= 1'b0;
            r_sample      <= c_POS;
            r_step        <= w_next_step;
            r_tone_idx    <= w_next_tone;
            r_half_period <= w_next_hp;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
         end else begin
            case (r_state)
               S_PLAY: begin
                  if (r_note_cnt == c_NOTE_LAST) begin
                     r_state    <= S_GAP;
                     r_note_cnt <= 32'd0;
                     r_gap_cnt  <= 32'd0;
                     r_sample   <= 24'd0;
                  end else begin
                     r_note_cnt <= r_note_cnt + 32'd1;
                     if (w_wave_wrap) begin
                        // sample follows the phase it is about to take
                        r_half_cnt <= 32'd0;
                        r_phase    <= ~r_phase;
                        r_sample   <= r_phase ? c_POS : c_NEG;
                     end else begin
                        r_half_cnt <= r_half_cnt + 32'd1;
                     end
                  end
               end
               S_GAP: begin
                  if (w_gap_end) begin
                     r_state  <= S_DONE;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                     r_sample <= 24'd0;
                  end else begin
                     r_gap_cnt <= r_gap_cnt + 32'd1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign audio_write = r_audio_write;
   assign sample      = r_sample;
   assign tone_idx    = r_tone_idx;
   assign half_period = r_half_period;
   assign step        = r_step;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_melody_sequencer
//  Directed bench: 20-cycle notes, 4-cycle gaps, half-periods 11,10,9,8,7,6,6,5.
//  Revision: 1.0  initial release
// ============================================================================
module tb_melody_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        stop;
   logic        audio_ready;
   logic        audio_write;
   logic [23:0] sample;
   logic [2:0]  tone_idx;
   logic [31:0] half_period;
   logic [3:0]  step;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int HP[8] = '{11, 10, 9, 8, 7, 6, 6, 5};

`ifdef MELODY_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   melody_sequencer #(
      .NUM_STEPS   (8),
      .MELODY      (48'h0000_00FA_C688),
      .NOTE_CYCLES (20),
      .GAP_CYCLES  (4),
      .AMPLITUDE   (24'h0F_FFFF),
      .DIV_SHIFT   (12)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .stop        (stop),
      .audio_ready (audio_ready),
      .audio_write (audio_write),
      .sample      (sample),
      .tone_idx    (tone_idx),
      .half_period (half_period),
      .step        (step),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected sample k cycles after the start edge (24 cycles per step)
   function automatic logic [31:0] exp_sample(input int k);
      int st;
      int pos;
      st  = (k / 24) % 8;
      pos = k % 24;
      if (pos >= 20) return 32'd0;
      return (((pos / HP[st]) % 2) == 1) ? 32'h00F0_0001 : 32'h000F_FFFF;
   endfunction

   initial begin
      reset_n     = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
      audio_ready = 1'b1;
      repeat (3) tick();
      chk("rst_write", 32'(audio_write), 32'd0);
      chk("rst_sample", 32'(sample), 32'd0);
      chk("rst_tone", 32'(tone_idx), 32'd0);
      chk("rst_hp", half_period, 32'd0);
      chk("rst_step", 32'(step), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("idle_write", 32'(audio_write), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // Full melody from a start edge
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("k0_busy", 32'(busy), 32'd1);
      chk("k0_tone", 32'(tone_idx), 32'd0);
      chk("k0_hp", half_period, 32'd11);
      chk("k0_sample", 32'(sample), 32'h000F_FFFF);
      chk("k0_write", 32'(audio_write), 32'd0);
      for (int k = 1; k < 200; k++) begin
         tick();
         if (k < 192 || LOOP) begin
            chk("run_step", 32'(step), 32'((k / 24) % 8));
            chk("run_tone", 32'(tone_idx), 32'((k / 24) % 8));
            chk("run_hp", half_period, 32'(HP[(k / 24) % 8]));
            chk("run_sample", 32'(sample), exp_sample(k));
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
         end else begin
            chk("end_done", 32'(done), 32'd1);
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_sample", 32'(sample), 32'd0);
         end
         chk("run_write", 32'(audio_write), 32'((k % 2 == 1) && (LOOP || k < 193)));
      end

      // Stop, then a note with the codec not ready
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_done", 32'(done), 32'd0);
      start       = 1'b1;
      audio_ready = 1'b0;
      tick();
      start = 1'b0;
      chk("nr_busy", 32'(busy), 32'd1);
      chk("nr_hp", half_period, 32'd11);
      chk("nr_write0", 32'(audio_write), 32'd0);
      for (int k = 1; k <= 24; k++) begin
         tick();
         chk("nr_write", 32'(audio_write), 32'd0);
      end
      chk("nr_step", 32'(step), 32'd1);
      chk("nr_tone", 32'(tone_idx), 32'd1);
      chk("nr_hp1", half_period, 32'd10);
      audio_ready = 1'b1;
      tick();
      chk("rdy_write1", 32'(audio_write), 32'd1);
      tick();
      chk("rdy_write2", 32'(audio_write), 32'd0);

      // Stop together with start in the middle of step 3
      repeat (54) tick();
      chk("mid3_step", 32'(step), 32'd3);
      chk("mid3_hp", half_period, 32'd8);
      stop  = 1'b1;
      start = 1'b1;
      tick();
      stop = 1'b0;
      chk("ss_busy", 32'(busy), 32'd0);
      chk("ss_step", 32'(step), 32'd0);
      chk("ss_sample", 32'(sample), 32'd0);
      chk("ss_write", 32'(audio_write), 32'd0);
      tick();
      chk("held_busy", 32'(busy), 32'd0);
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_sample", 32'(sample), 32'h000F_FFFF);

      // Reset in the middle of a note
      repeat (3) tick();
      reset_n = 1'b0;
      tick();
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_sample", 32'(sample), 32'd0);
      chk("mrst_hp", half_period, 32'd0);
      chk("mrst_write", 32'(audio_write), 32'd0);
      reset_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
